exec_ctrl: RTL and testbench

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/exec_ctrl.sv | 176 +++++++++++++++++
 tb/tb_exec_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_ctrl.sv
// Execute-stage sequencer: accepts one op, drives an external combinational ALU, holds the shaped result.
// Optional macro EXEC_SERIAL_SHIFT_EN routes nonzero logical/arithmetic shifts through a one-bit-per-cycle SHIFT loop.
//
// state | meaning
// IDLE  | ready for a new op
// RUN   | single-cycle ALU evaluation of the latched op
// SHIFT | serial shift, one bit per cycle until count reaches 1
// HOLD  | result presented, waiting for out_ready
module exec_ctrl #(
  parameter int REGISTER_WIDTH = 32,
  parameter int ALU_CTRL_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ALU_CTRL_WIDTH-1:0] in_op,
  input  logic [REGISTER_WIDTH-1:0] in_opa,
  input  logic [REGISTER_WIDTH-1:0] in_opb,
  output logic [ALU_CTRL_WIDTH-1:0] alu_op,
  output logic [REGISTER_WIDTH-1:0] alu_a,
  output logic [REGISTER_WIDTH-1:0] alu_b,
  input  logic [REGISTER_WIDTH-1:0] alu_out,
  input  logic                      alu_bcond,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REGISTER_WIDTH-1:0] out_result,
  output logic                      out_bcond,
  output logic                      busy
);

  localparam int OP_MSB = ALU_CTRL_WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                      w_accept;
  logic                      w_capture;
  logic                      w_branch_grp;
  logic [ALU_CTRL_WIDTH-1:0] r_op;
  logic [REGISTER_WIDTH-1:0] r_opa;
  logic [REGISTER_WIDTH-1:0] r_opb;
  logic [REGISTER_WIDTH-1:0] r_result;
  logic                      r_bcond;

`ifdef EXEC_SERIAL_SHIFT_EN
  logic [4:0]                r_cnt;
  logic [REGISTER_WIDTH-1:0] r_acc;
  logic                      w_shift_start;

  assign w_shift_start = ~in_op[OP_MSB]
                       & ((in_op[3:0] == 4'b0001) | (in_op[3:0] == 4'b0101) | (in_op[3:0] == 4'b1101))
                       & (in_opb[4:0] != 5'd0);
`endif

  assign in_ready   = (r_state == S_IDLE) & ~flush & ~rst;
  assign w_accept   = in_valid & in_ready;
  assign busy       = (r_state != S_IDLE);
  assign out_valid  = (r_state == S_HOLD);
  assign out_result = r_result;
  assign out_bcond  = r_bcond;

  // Branch group reports only the condition; JALR/LUI live in the same group but return a value.
  assign w_branch_grp = r_op[OP_MSB] & (r_op[3:0] != 4'b1000) & (r_op[3:0] != 4'b1001);

`ifdef EXEC_SERIAL_SHIFT_EN
  assign w_capture = ~flush & ((r_state == S_RUN) | ((r_state == S_SHIFT) & (r_cnt == 5'd1)));
`else
  assign w_capture = ~flush & (r_state == S_RUN);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
`ifdef EXEC_SERIAL_SHIFT_EN
            w_next = w_shift_start ? S_SHIFT : S_RUN;
`else
            w_next = S_RUN;
`endif
          end
        end
        S_RUN:  w_next = S_HOLD;
`ifdef EXEC_SERIAL_SHIFT_EN
        S_SHIFT: begin
          if (r_cnt == 5'd1) w_next = S_HOLD;
        end
`endif
        S_HOLD: begin
          if (out_ready) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    case (r_state)
      S_RUN: begin
        alu_op = r_op;
        alu_a  = r_opa;
        alu_b  = r_opb;
      end
`ifdef EXEC_SERIAL_SHIFT_EN
      S_SHIFT: begin
        alu_op = r_op;
        alu_a  = r_acc;
        alu_b  = {{(REGISTER_WIDTH-1){1'b0}}, 1'b1};
      end
`endif
      default: begin
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_bcond  <= 1'b0;
`ifdef EXEC_SERIAL_SHIFT_EN
      r_cnt    <= 5'd0;
      r_acc    <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_op  <= in_op;
        r_opa <= in_opa;
        r_opb <= in_opb;
`ifdef EXEC_SERIAL_SHIFT_EN
        r_cnt <= in_opb[4:0];
        r_acc <= in_opa;
`endif
      end
`ifdef EXEC_SERIAL_SHIFT_EN
      if ((r_state == S_SHIFT) && !flush) begin
        r_acc <= alu_out;
        r_cnt <= r_cnt - 5'd1;
      end
`endif
      if (w_capture) begin
        r_result <= w_branch_grp ? '0 : alu_out;
        r_bcond  <= w_branch_grp ? alu_bcond : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: a stub ALU, a spec-level reference model and randomized op traffic.
// Latency expectations follow EXEC_SERIAL_SHIFT_EN when the macro is defined for the build.
module tb_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, alu_bcond, out_valid, out_bcond, busy;
  logic [4:0]  in_op, alu_op;
  logic [31:0] in_opa, in_opb, alu_a, alu_b, alu_out, out_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_ctrl #(.REGISTER_WIDTH(32), .ALU_CTRL_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_opa(in_opa), .in_opb(in_opb),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_bcond(alu_bcond),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_bcond(out_bcond), .busy(busy)
  );

  // Stub ALU: {bcond, out}. Non-branch ops report a==b on bcond so result shaping is observable.
  function automatic logic [32:0] alu_calc(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] o;
    logic        bc;
    o  = a + b;
    bc = (a == b);
    if (op[4]) begin
      case (op[3:0])
        4'b1000: o = a + b;
        4'b1001: o = b;
        default: o = a - b;
      endcase
      case (op[2:0])
        3'b000:  bc = (a == b);
        3'b001:  bc = (a != b);
        3'b100:  bc = ($signed(a) < $signed(b));
        3'b101:  bc = ($signed(a) >= $signed(b));
        3'b110:  bc = (a < b);
        3'b111:  bc = (a >= b);
        default: bc = 1'b0;
      endcase
    end else begin
      case (op[3:0])
        4'b0000: o = a + b;
        4'b1000: o = a - b;
        4'b0001: o = a << b[4:0];
        4'b0101: o = a >> b[4:0];
        4'b1101: o = $signed(a) >>> b[4:0];
        4'b0100: o = a ^ b;
        4'b0110: o = a | b;
        4'b0111: o = a & b;
        4'b0010: o = {31'd0, $signed(a) < $signed(b)};
        4'b0011: o = {31'd0, a < b};
        default: o = a + b;
      endcase
    end
    return {bc, o};
  endfunction

  assign {alu_bcond, alu_out} = alu_calc(alu_op, alu_a, alu_b);

  function automatic bit is_cond_op(input logic [4:0] op);
    return op[4] && (op[3:0] != 4'b1000) && (op[3:0] != 4'b1001);
  endfunction

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    r = alu_calc(op, a, b);
    return is_cond_op(op) ? 32'd0 : r[31:0];
  endfunction

  function automatic logic ref_bcond(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    r = alu_calc(op, a, b);
    return is_cond_op(op) ? r[32] : 1'b0;
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] b);
    int lat;
    lat = 2;
`ifdef EXEC_SERIAL_SHIFT_EN
    if (!op[4] && (op[3:0] == 4'b0001 || op[3:0] == 4'b0101 || op[3:0] == 4'b1101) && b[4:0] != 5'd0)
      lat = 1 + int'(b[4:0]);
`endif
    return lat;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] e_res;
    logic        e_bc;
    int          lat, c;
    bit          got;
    e_res = ref_result(op, a, b);
    e_bc  = ref_bcond(op, a, b);
    lat   = ref_lat(op, b);
    in_valid = 1'b1; in_op = op; in_opa = a; in_opb = b; out_ready = (hold == 0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_ready op=%b got=%b exp=1", op, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 5'($urandom); in_opa = $urandom; in_opb = $urandom;
    c = 0; got = 0;
    while (!got && c < 40) begin
      @(negedge clk); c++;
      if (out_valid === 1'b1) got = 1;
      else begin
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL in_flight_flags busy=%b in_ready=%b exp 1/0", busy, in_ready); end
        checks++; if (alu_op !== op) begin errors++; $display("FAIL alu_op got=%b exp=%b", alu_op, op); end
        if (c == 1) begin
          checks++; if (alu_a !== a) begin errors++; $display("FAIL alu_a_first got=%h exp=%h", alu_a, a); end
        end
        if (lat == 2) begin
          checks++; if (alu_b !== b) begin errors++; $display("FAIL run_alu_b got=%h exp=%h", alu_b, b); end
        end else begin
          checks++; if (alu_b !== 32'd1) begin errors++; $display("FAIL shift_alu_b got=%h exp=1", alu_b); end
        end
      end
    end
    checks++; if (!got || c != lat) begin errors++; $display("FAIL latency op=%b b=%h got=%0d exp=%0d", op, b, got ? c : -1, lat); end
    if (got) begin
      checks++; if (out_result !== e_res) begin errors++; $display("FAIL result op=%b a=%h b=%h got=%h exp=%h", op, a, b, out_result, e_res); end
      checks++; if (out_bcond !== e_bc) begin errors++; $display("FAIL bcond op=%b a=%h b=%h got=%b exp=%b", op, a, b, out_bcond, e_bc); end
      checks++; if (alu_op !== 5'd0 || alu_a !== 32'd0 || alu_b !== 32'd0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_outputs alu_op=%b alu_a=%h alu_b=%h in_ready=%b exp zeros", alu_op, alu_a, alu_b, in_ready);
      end
    end
    if (hold > 0) begin
      for (int h = 1; h < hold; h++) begin
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_result !== e_res || out_bcond !== e_bc || in_ready !== 1'b0) begin
          errors++; $display("FAIL backpressure_hold valid=%b result=%h in_ready=%b exp 1/%h/0", out_valid, out_result, in_ready, e_res);
        end
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL return_idle busy=%b valid=%b exp 0/0", busy, out_valid); end
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_op = 5'd0; in_opa = 32'd3; in_opb = 32'd4;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags in_ready=%b busy=%b exp 0/0", in_ready, busy); end
    checks++; if (out_valid !== 1'b0 || out_result !== 32'd0 || out_bcond !== 1'b0) begin
      errors++; $display("FAIL reset_outputs valid=%b result=%h bcond=%b exp zeros", out_valid, out_result, out_bcond);
    end
    in_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || alu_op !== 5'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      errors++; $display("FAIL post_reset in_ready=%b busy=%b alu_op=%b alu_a=%h alu_b=%h", in_ready, busy, alu_op, alu_a, alu_b);
    end
  endtask

  task automatic test_add;
    do_op(5'b00000, 32'd5, 32'd7, 0);
  endtask

  task automatic test_branch;
    do_op(5'b10100, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(5'b10111, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(5'b11000, 32'd9, 32'd9, 0);
    do_op(5'b11001, 32'd1, 32'h1234_5000, 0);
  endtask

  task automatic test_shift;
    do_op(5'b01101, 32'h8000_0000, 32'd4, 0);
    do_op(5'b01101, 32'h8000_0000, 32'd0, 0);
    do_op(5'b00001, 32'h0000_0001, 32'd31, 0);
    do_op(5'b00101, 32'hF000_0000, 32'hFFFF_FFE1, 0);
  endtask

  task automatic test_backpressure;
    do_op(5'b00110, $urandom, $urandom, 3);
  endtask

  task automatic test_flush;
    int fc;
    bit seen;
`ifdef EXEC_SERIAL_SHIFT_EN
    fc = 3;
`else
    fc = 1;
`endif
    seen = 0;
    in_valid = 1'b1; in_op = 5'b00001; in_opa = 32'h0000_00FF; in_opb = 32'd20; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= fc; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1;
    end
    flush = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_to_idle busy=%b valid=%b exp 0/0", busy, out_valid); end
    flush = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL flush_discard out_valid got=1 exp=0"); end
    flush = 1'b1; in_valid = 1'b1; in_op = 5'b00000;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_blocks_accept busy got=%b exp=0", busy); end
    flush = 1'b0; in_valid = 1'b1; in_opa = 32'd1; in_opb = 32'd2; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_before_flush valid got=%b exp=1", out_valid); end
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_in_hold valid=%b busy=%b exp 0/0", out_valid, busy); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset_mid;
    in_valid = 1'b1; in_op = 5'b00000; in_opa = 32'd5; in_opb = 32'd7; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd12) begin errors++; $display("FAIL pre_reset_hold valid=%b result=%h exp 1/0000000c", out_valid, out_result); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_result !== 32'd0 || out_bcond !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mid_hold valid=%b result=%h bcond=%b busy=%b in_ready=%b exp zeros", out_valid, out_result, out_bcond, busy, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_op = 5'b01101; in_opa = 32'h8000_0000; in_opb = 32'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || alu_op !== 5'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      errors++; $display("FAIL reset_mid_op busy=%b valid=%b alu_op=%b alu_a=%h alu_b=%h exp zeros", busy, out_valid, alu_op, alu_a, alu_b);
    end
    rst = 1'b0; flush = 1'b0;
    @(negedge clk);
    do_op(5'b01000, 32'd100, 32'd58, 0);
  endtask

  task automatic test_random;
    logic [4:0]  pool [18];
    logic [4:0]  op;
    logic [31:0] a, b;
    int          hold;
    pool = '{5'b00000, 5'b01000, 5'b00001, 5'b00101, 5'b01101, 5'b00100, 5'b00110, 5'b00111, 5'b00010,
             5'b00011, 5'b10000, 5'b10001, 5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b11000, 5'b11001};
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : pool[$urandom_range(0, 17)];
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
      hold = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      do_op(op, a, b, hold);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_branch;
    test_shift;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
